// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage ALU and its surrounding datapath.
// The master drives operands and opcode; the slave (the ALU) returns registered results.
interface alu_if;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic [3:0]  nzcv;
    logic        result_writeback;
    logic        nzcv_writeback;

    modport master (
        output operand_a, operand_b, alu_control,
        input  result, nzcv, result_writeback, nzcv_writeback
    );

    modport slave (
        input  operand_a, operand_b, alu_control,
        output result, nzcv, result_writeback, nzcv_writeback
    );
endinterface

// File: rtl/alu.sv
// ARM7TDMI-style data-processing ALU: combinational datapath, registered result,
// NZCV flag register that also supplies the carry-in for ADC/SBC/RSC chaining.
module alu (
    input  logic clk,
    input  logic reset,
    alu_if.slave bus
);
    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } op_e;

    op_e         op;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic        is_arith;
    logic [32:0] sum;
    logic [31:0] logic_res;

    logic [31:0] result_d, result_q;
    logic [3:0]  nzcv_d, nzcv_q;
    logic        result_wb_d, result_wb_q;
    logic        nzcv_wb_d, nzcv_wb_q;

    assign op = op_e'(bus.alu_control);
    assign a  = bus.operand_a;
    assign b  = bus.operand_b;

    // Every arithmetic opcode is folded onto one 33-bit adder: x + y + cin,
    // with subtraction expressed as x + ~y + cin.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        add_x     = a;
        add_y     = b;
        add_cin   = 1'b0;
        is_arith  = 1'b0;
        logic_res = '0;
        case (op)
            OP_SUB, OP_CMP: begin
                add_y    = ~b;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            OP_RSB: begin
                add_x    = b;
                add_y    = ~a;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                is_arith = 1'b1;
            end
            OP_ADC: begin
                add_cin  = nzcv_q[1];
                is_arith = 1'b1;
            end
            OP_SBC: begin
                add_y    = ~b;
                add_cin  = nzcv_q[1];
                is_arith = 1'b1;
            end
            OP_RSC: begin
                add_x    = b;
                add_y    = ~a;
                add_cin  = nzcv_q[1];
                is_arith = 1'b1;
            end
            OP_AND, OP_TST: logic_res = a & b;
            OP_EOR, OP_TEQ: logic_res = a ^ b;
            OP_ORR:         logic_res = a | b;
            OP_MOV:         logic_res = b;
            OP_BIC:         logic_res = a & ~b;
            OP_MVN:         logic_res = ~b;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    always_comb begin
        result_d    = is_arith ? sum[31:0] : logic_res;
        nzcv_d[3]   = result_d[31];
        nzcv_d[2]   = (result_d == 32'd0);
        // Logical opcodes have no shifter carry input here, so C and V simply persist.
        nzcv_d[1]   = is_arith ? sum[32] : nzcv_q[1];
        nzcv_d[0]   = is_arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31]))
                               : nzcv_q[0];
        result_wb_d = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
        nzcv_wb_d   = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (reset) begin
            result_q    <= '0;
            nzcv_q      <= '0;
            result_wb_q <= 1'b0;
            nzcv_wb_q   <= 1'b0;
        end else begin
            result_q    <= result_d;
            nzcv_q      <= nzcv_d;
            result_wb_q <= result_wb_d;
            nzcv_wb_q   <= nzcv_wb_d;
        end
    end

    assign bus.result           = result_q;
    assign bus.nzcv             = nzcv_q;
    assign bus.result_writeback = result_wb_q;
    assign bus.nzcv_writeback   = nzcv_wb_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset corner cases,
// and randomized operations compared against an arithmetic reference model.
module tb_alu;
    logic clk;
    logic reset;
    alu_if bus ();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int failures;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic [3:0]  exp_nzcv;
        logic        exp_rwb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one operation, let the edge capture it, then sample away from the edge.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_control = op;
        bus.operand_a   = a;
        bus.operand_b   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] r, input logic [3:0] f,
                             input logic rwb, input logic nwb);
        check({tag, ".result"}, bus.result, r);
        check({tag, ".nzcv"}, {28'd0, bus.nzcv}, {28'd0, f});
        check({tag, ".result_wb"}, {31'd0, bus.result_writeback}, {31'd0, rwb});
        check({tag, ".nzcv_wb"}, {31'd0, bus.nzcv_writeback}, {31'd0, nwb});
    endtask

    // Reference model: ARM semantics computed with wide integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] flags, output logic [31:0] r,
                                  output logic [3:0] nf, output logic rwb);
        longint ua, ub, sa, sb, full, sres, cin, borrow;
        logic c, v, arith;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cin = flags[1] ? 64'sd1 : 64'sd0;
        borrow = 1 - cin;
        c = flags[1];
        v = flags[0];
        arith = 1'b1;
        r = '0;
        case (op)
            4'h2, 4'hA: begin full = ua - ub;          sres = sa - sb;          c = (ua >= ub); end
            4'h3:       begin full = ub - ua;          sres = sb - sa;          c = (ub >= ua); end
            4'h4, 4'hB: begin full = ua + ub;          sres = sa + sb;          c = (full >= 64'sh1_0000_0000); end
            4'h5:       begin full = ua + ub + cin;    sres = sa + sb + cin;    c = (full >= 64'sh1_0000_0000); end
            4'h6:       begin full = ua - ub - borrow; sres = sa - sb - borrow; c = (ua >= ub + borrow); end
            4'h7:       begin full = ub - ua - borrow; sres = sb - sa - borrow; c = (ub >= ua + borrow); end
            default: begin
                arith = 1'b0;
                full = 0;
                sres = 0;
            end
        endcase
        if (arith) begin
            r = full[31:0];
            v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        end else begin
            case (op)
                4'h0, 4'h8: r = a & b;
                4'h1, 4'h9: r = a ^ b;
                4'hC:       r = a | b;
                4'hD:       r = b;
                4'hE:       r = a & ~b;
                default:    r = ~b;
            endcase
        end
        nf = {r[31], r == 32'd0, c, v};
        rwb = !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
    endfunction

    initial begin
        logic [31:0] mr;
        logic [3:0]  mf;
        logic        mrwb;
        logic [3:0]  flags;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        tests = 0;
        failures = 0;

        // Directed vectors, applied back-to-back so flags chain from row to row.
        vecs.push_back('{4'h0, 32'hCC, 32'hAA, 32'h00000088, 4'b0000, 1'b1});
        vecs.push_back('{4'h1, 32'hCC, 32'hAA, 32'h00000066, 4'b0000, 1'b1});
        vecs.push_back('{4'hC, 32'hCC, 32'hAA, 32'h000000EE, 4'b0000, 1'b1});
        vecs.push_back('{4'hE, 32'hCC, 32'hAA, 32'h00000044, 4'b0000, 1'b1});
        vecs.push_back('{4'hD, 32'hCC, 32'hAA, 32'h000000AA, 4'b0000, 1'b1});
        vecs.push_back('{4'hF, 32'hCC, 32'hAA, 32'hFFFFFF55, 4'b1000, 1'b1});
        vecs.push_back('{4'h2, 32'd20, 32'd15, 32'd5,        4'b0010, 1'b1});
        vecs.push_back('{4'h3, 32'd5,  32'd10, 32'd5,        4'b0010, 1'b1});
        vecs.push_back('{4'h2, 32'd5,  32'd10, 32'hFFFFFFFB, 4'b1000, 1'b1});
        vecs.push_back('{4'h4, 32'hFFFFFFFF, 32'd1, 32'd0,   4'b0110, 1'b1});
        vecs.push_back('{4'h5, 32'd10, 32'd15, 32'd26,       4'b0000, 1'b1});
        vecs.push_back('{4'h4, 32'd5,  32'd3,  32'd8,        4'b0000, 1'b1});
        vecs.push_back('{4'h5, 32'd10, 32'd15, 32'd25,       4'b0000, 1'b1});
        vecs.push_back('{4'h2, 32'd20, 32'd15, 32'd5,        4'b0010, 1'b1});
        vecs.push_back('{4'h6, 32'd15, 32'd8,  32'd7,        4'b0010, 1'b1});
        vecs.push_back('{4'h7, 32'd15, 32'd20, 32'd5,        4'b0010, 1'b1});
        vecs.push_back('{4'h4, 32'd5,  32'd3,  32'd8,        4'b0000, 1'b1});
        vecs.push_back('{4'h6, 32'd15, 32'd8,  32'd6,        4'b0010, 1'b1});
        vecs.push_back('{4'hA, 32'd10, 32'd5,  32'd5,        4'b0010, 1'b0});
        vecs.push_back('{4'hB, 32'd10, 32'd5,  32'd15,       4'b0000, 1'b0});
        vecs.push_back('{4'h8, 32'hCC, 32'h33, 32'd0,        4'b0100, 1'b0});
        vecs.push_back('{4'h9, 32'hCC, 32'hAA, 32'h00000066, 4'b0000, 1'b0});
        vecs.push_back('{4'h4, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001, 1'b1});
        vecs.push_back('{4'h2, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011, 1'b1});
        vecs.push_back('{4'h0, 32'hCC, 32'hAA, 32'h00000088, 4'b0011, 1'b1});

        reset = 1'b1;
        bus.alu_control = 4'h4;
        bus.operand_a   = 32'd1;
        bus.operand_b   = 32'd2;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 32'd0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_nzcv,
                      vecs[i].exp_rwb, 1'b1);
        end

        // Reset with ADD present discards the op; flags had C=1,V=1 beforehand.
        reset = 1'b1;
        apply(4'h4, 32'd100, 32'd200);
        check_all("reset_mid", 32'd0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        // First operation after reset must see C=0.
        apply(4'h5, 32'd1, 32'd2);
        check_all("adc_after_reset", 32'd3, 4'b0000, 1'b1, 1'b1);

        // Two-word chained add: 0x00000001_FFFFFFFF + 0x00000002_00000001.
        apply(4'h4, 32'hFFFFFFFF, 32'h00000001);
        check_all("chain_lo", 32'd0, 4'b0110, 1'b1, 1'b1);
        apply(4'h5, 32'h00000001, 32'h00000002);
        check_all("chain_hi", 32'd4, 4'b0000, 1'b1, 1'b1);

        // Randomized run against the model, with occasional resets.
        flags = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'h7FFFFFFF + 32'($urandom_range(0, 2)); rb = 32'($urandom_range(0, 2)); end
                2: begin ra = 32'($urandom_range(0, 3)); rb = 32'hFFFFFFFF - 32'($urandom_range(0, 2)); end
                default: begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(0, 20)); end
            endcase
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                apply(rop, ra, rb);
                reset = 1'b0;
                flags = 4'b0000;
                check_all($sformatf("rnd%0d_rst", i), 32'd0, 4'b0000, 1'b0, 1'b0);
            end else begin
                model(rop, ra, rb, flags, mr, mf, mrwb);
                apply(rop, ra, rb);
                flags = mf;
                check_all($sformatf("rnd%0d_op%0h", i, rop), mr, mf, mrwb, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
